// File: rtl/conn_box_dbuf_if.sv
// -----------------------------------------------------------------------------
// conn_box_dbuf_if
// Bundle of configuration-chain and fabric signals for one conn_box_dbuf.
//
// Parameters:
//   INPUTS  - number of routing tracks  (width of `in`)
//   OUTPUTS - number of output pins     (width of `out`)
//
// Signals:
//   prog_en      shift enable for the scan chain
//   prog_in      serial configuration data in
//   prog_commit  single-cycle request to apply the shadow register
//   in           routing tracks (fabric data, not clocked)
//   prog_out     serial data out (shadow bit 0), feeds the next box
//   out          selected tracks
//   prog_done    sticky, set by an accepted commit
//   prog_err     sticky, set by a rejected commit
//
// Modports:
//   master - the configuration controller / fabric side (drives the inputs)
//   slave  - the connection box itself
//
// Transfer semantics: there is no valid/ready pair. A bit is transferred on
// every rising prog_clk edge where prog_en = 1. A commit is a one-edge request
// taken on the rising edge where prog_commit = 1. It is accepted only with
// prog_en = 0 and exactly one full frame shifted since the last commit or
// reset. The outcome is reported on prog_done / prog_err from that same edge
// onward.
// -----------------------------------------------------------------------------
interface conn_box_dbuf_if #(
  parameter int INPUTS  = 16,
  parameter int OUTPUTS = 20
);
  logic               prog_en;
  logic               prog_in;
  logic               prog_commit;
  logic [INPUTS-1:0]  in;
  logic               prog_out;
  logic [OUTPUTS-1:0] out;
  logic               prog_done;
  logic               prog_err;

  modport master (
    output prog_en,
    output prog_in,
    output prog_commit,
    output in,
    input  prog_out,
    input  out,
    input  prog_done,
    input  prog_err
  );

  modport slave (
    input  prog_en,
    input  prog_in,
    input  prog_commit,
    input  in,
    output prog_out,
    output out,
    output prog_done,
    output prog_err
  );
endinterface

// File: rtl/conn_box_dbuf.sv
// -----------------------------------------------------------------------------
// conn_box_dbuf
// Double-buffered FPGA connection box. Each of OUTPUTS pins selects one of
// INPUTS routing tracks. Each pin also has its own enable bit. Configuration
// is shifted serially into a shadow register and then copied into the active
// register by a commit. The commit is applied only when exactly one full frame
// has been shifted.
//
// Parameters:
//   INPUTS  (>= 2)  number of routing tracks
//   OUTPUTS (>= 1)  number of output pins
//
// Ports:
//   prog_clk    configuration clock, rising edge
//   prog_rst_n  asynchronous active-low reset
//   bus         conn_box_dbuf_if.slave:
//                 prog_en/prog_in/prog_commit in, prog_out/prog_done/prog_err out,
//                 in (tracks) in, out (pins) out
//
// Field k of the frame occupies shadow[k*FW +: FW]. Bit FW-1 is the enable
// and bits SEL_W-1:0 are the select. The first bit shifted in ends up in
// shadow[0], so a frame is sent field 0 first, LSB first.
// -----------------------------------------------------------------------------
module conn_box_dbuf #(
  parameter int INPUTS  = 16,
  parameter int OUTPUTS = 20
) (
  input  logic           prog_clk,
  input  logic           prog_rst_n,
  conn_box_dbuf_if.slave bus
);

  localparam int SEL_W     = $clog2(INPUTS);
  localparam int FW        = SEL_W + 1;
  localparam int CHAIN_LEN = OUTPUTS * FW;
  // The counter must hold 0..CHAIN_LEN+1. CHAIN_LEN+1 is the sticky
  // "overrun" value.
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
  // The track vector is zero-padded up to a power of two, so that
  // out-of-range selects read a constant 0 instead of indexing past `in`.
  localparam int PAD_W     = 1 << SEL_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CHAIN_LEN-1:0] r_shadow;
  logic [CHAIN_LEN-1:0] r_active;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_done;
  logic                 r_err;

  logic                 w_frame_ok;
  logic [PAD_W-1:0]     w_in_pad;
  logic [OUTPUTS-1:0]   w_out;

  assign w_frame_ok = (r_bit_cnt == CNT_FULL);

  // ---------------------------------------------------------------------------
  // Scan chain, frame counter, commit and status flags.
  // A shift always takes priority over a commit. A commit arriving together
  // with a shift is rejected, and it does not clear the counter, so the frame
  // in progress is still valid for a later lone commit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else if (bus.prog_en) begin
      r_shadow <= {bus.prog_in, r_shadow[CHAIN_LEN-1:1]};
      if (r_bit_cnt != CNT_SAT) begin
        r_bit_cnt <= r_bit_cnt + CNT_ONE;
      end
      r_done <= 1'b0;
      if (bus.prog_commit) begin
        r_err <= 1'b1;
      end
    end else if (bus.prog_commit) begin
      r_bit_cnt <= '0;
      if (w_frame_ok) begin
        r_active <= r_shadow;
        r_done   <= 1'b1;
        r_err    <= 1'b0;
      end else begin
        r_done   <= 1'b0;
        r_err    <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mux. It is purely combinational from r_active and in. r_active
  // changes as a whole on one edge, so a commit can never expose a mix of the
  // old and new configurations.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_in_pad             = '0;
    w_in_pad[INPUTS-1:0] = bus.in;
  end

  always_comb begin
    w_out = '0;
    for (int k = 0; k < OUTPUTS; k++) begin
      w_out[k] = r_active[k*FW + FW - 1] & w_in_pad[r_active[k*FW +: SEL_W]];
    end
  end

  assign bus.prog_out  = r_shadow[0];
  assign bus.out       = w_out;
  assign bus.prog_done = r_done;
  assign bus.prog_err  = r_err;

endmodule

// File: tb/tb_conn_box_dbuf.sv
// -----------------------------------------------------------------------------
// tb_conn_box_dbuf
// Two boxes share one configuration stream and one clock/reset:
//   dut16 - INPUTS = 16 (power of two)
//   dut12 - INPUTS = 12 (SEL_W = 4, out-of-range selects 12..15 exist)
// Both boxes have CHAIN_LEN = 100.
//
// Once per cycle the driver pushes the model's prediction for the window that
// follows: the state after the previous edge, combined with the `in` value it
// has just applied. The monitor pops one prediction at each falling edge and
// compares it.
//
// The model keeps the shadow chain as a 100-deep bit FIFO, together with a
// frame-length count, the flags, and the committed bits. The outputs are
// recomputed from the decoded fields.
// -----------------------------------------------------------------------------
module tb_conn_box_dbuf;

  localparam int N    = 100;
  localparam int OUTS = 20;
  localparam int W    = 2 * (3 + OUTS);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en_d     = 1'b0;
  logic        din_d    = 1'b0;
  logic        commit_d = 1'b0;
  logic [15:0] in_d     = 16'h0;

  conn_box_dbuf_if #(.INPUTS(16), .OUTPUTS(OUTS)) bus16 ();
  conn_box_dbuf_if #(.INPUTS(12), .OUTPUTS(OUTS)) bus12 ();

  assign bus16.prog_en     = en_d;
  assign bus16.prog_in     = din_d;
  assign bus16.prog_commit = commit_d;
  assign bus16.in          = in_d;
  assign bus12.prog_en     = en_d;
  assign bus12.prog_in     = din_d;
  assign bus12.prog_commit = commit_d;
  assign bus12.in          = in_d[11:0];

  conn_box_dbuf #(.INPUTS(16), .OUTPUTS(OUTS)) dut16 (
    .prog_clk   (clk),
    .prog_rst_n (rst_n),
    .bus        (bus16)
  );

  conn_box_dbuf #(.INPUTS(12), .OUTPUTS(OUTS)) dut12 (
    .prog_clk   (clk),
    .prog_rst_n (rst_n),
    .bus        (bus12)
  );

  // ---------------- reference model ----------------
  logic sh_m[$];          // sh_m[0] is the bit next to leave the chain
  logic act_m[N];
  int   cnt_m;
  logic done_m;
  logic err_m;

  task automatic model_reset();
    sh_m.delete();
    repeat (N) sh_m.push_back(1'b0);
    for (int i = 0; i < N; i++) act_m[i] = 1'b0;
    cnt_m  = 0;
    done_m = 1'b0;
    err_m  = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic din, input logic commit);
    logic dropped;
    if (en) begin
      dropped = sh_m.pop_front();
      sh_m.push_back(din);
      if (cnt_m < N + 1) cnt_m++;
      done_m = 1'b0;
      if (commit) err_m = 1'b1;
    end else if (commit) begin
      if (cnt_m == N) begin
        for (int i = 0; i < N; i++) act_m[i] = sh_m[i];
        done_m = 1'b1;
        err_m  = 1'b0;
      end else begin
        done_m = 1'b0;
        err_m  = 1'b1;
      end
      cnt_m = 0;
    end
  endtask

  function automatic logic [OUTS-1:0] model_out(input int inputs, input logic [15:0] inv);
    logic [OUTS-1:0] r;
    r = '0;
    for (int k = 0; k < OUTS; k++) begin
      int sel;
      sel = 0;
      for (int b = 0; b < 4; b++) if (act_m[k*5 + b]) sel += (1 << b);
      if (act_m[k*5 + 4] && sel < inputs) r[k] = inv[sel];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_vec(input logic [15:0] inv);
    return {done_m, err_m, sh_m[0], model_out(16, inv),
            done_m, err_m, sh_m[0], model_out(12, inv)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_pass  = 0;
  int           n_total = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus16.prog_done, bus16.prog_err, bus16.prog_out, bus16.out,
            bus12.prog_done, bus12.prog_err, bus12.prog_out, bus12.out};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] rin();
    return 16'($urandom_range(0, 65535));
  endfunction

  // Called at posedge+1: apply inputs, predict this window, then take the edge.
  task automatic cyc(input logic en, input logic din, input logic commit,
                     input logic [15:0] inv, input string nm);
    en_d     = en;
    din_d    = din;
    commit_d = commit;
    in_d     = inv;
    exp_q.push_back(model_vec(inv));
    name_q.push_back(nm);
    @(posedge clk);
    if (rst_n) model_edge(en, din, commit);
    #1;
  endtask

  // Asserts or releases reset away from the clock edge.
  task automatic rst_cyc(input logic r, input logic [15:0] inv, input string nm);
    en_d     = 1'b0;
    din_d    = 1'b0;
    commit_d = 1'b0;
    in_d     = inv;
    rst_n    = r;
    if (!r) model_reset();
    exp_q.push_back(model_vec(inv));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] mk_frame(input int f0_sel, input int f0_en);
    logic [N-1:0] fr;
    for (int k = 0; k < OUTS; k++) begin
      fr[k*5 +: 5] = 5'($urandom_range(0, 31));
    end
    if (f0_sel >= 0) fr[3:0] = 4'(f0_sel);
    if (f0_en >= 0)  fr[4]   = 1'(f0_en);
    return fr;
  endfunction

  task automatic shift_frame(input logic [N-1:0] fr, input int nbits,
                             input logic fix_in, input logic [15:0] fixv,
                             input string nm);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = (i < N) ? fr[i] : 1'($urandom_range(0, 1));
      cyc(1'b1, b, 1'b0, fix_in ? fixv : rin(), nm);
    end
  endtask

  task automatic commit_idle(input string nm, input int idle);
    cyc(1'b0, 1'b0, 1'b1, rin(), nm);
    for (int i = 0; i < idle; i++) cyc(1'b0, 1'b0, 1'b0, rin(), {nm, "_idle"});
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] fr;
  logic [15:0]  lfsr;

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    // reset state, including the all-ones track pattern
    rst_cyc(1'b0, 16'hFFFF, "reset_state");
    rst_cyc(1'b0, rin(), "reset_state");
    rst_cyc(1'b1, rin(), "reset_release");

    // full frame: every field enabled, sel = k mod 16, in = A5A5
    for (int k = 0; k < OUTS; k++) fr[k*5 +: 5] = {1'b1, 4'(k % 16)};
    shift_frame(fr, N, 1'b1, 16'hA5A5, "full_shift");
    cyc(1'b0, 1'b0, 1'b1, 16'hA5A5, "full_commit");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 16'hA5A5, "full_out");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, rin(), "full_out_rand");

    // short frame, long frame, then a correct one
    shift_frame(mk_frame(-1, -1), N - 1, 1'b0, 16'h0, "short_shift");
    commit_idle("short_commit", 3);
    shift_frame(mk_frame(-1, -1), N + 1, 1'b0, 16'h0, "long_shift");
    commit_idle("long_commit", 3);
    shift_frame(mk_frame(-1, -1), N, 1'b0, 16'h0, "good_shift");
    commit_idle("good_commit", 3);

    // re-commit without shifting is rejected
    commit_idle("recommit", 2);

    // pass-through of a PRBS stream
    lfsr = 16'hACE1;
    for (int i = 0; i < 2 * N; i++) begin
      cyc(1'b1, lfsr[0], 1'b0, rin(), "passthru");
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    commit_idle("passthru_commit", 2);

    // commit during the 100th shift is rejected, then a lone commit is accepted
    fr = mk_frame(-1, -1);
    shift_frame(fr, N - 1, 1'b0, 16'h0, "cds_shift");
    cyc(1'b1, fr[N-1], 1'b1, rin(), "cds_commit_shift");
    cyc(1'b0, 1'b0, 1'b0, rin(), "cds_after");
    commit_idle("cds_lone_commit", 3);

    // out-of-range select on the 12-track box, then sel 11, then disabled
    shift_frame(mk_frame(13, 1), N, 1'b0, 16'h0, "sel13_shift");
    cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, "sel13_commit");
    cyc(1'b0, 1'b0, 1'b0, 16'hFFFF, "sel13_ones");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, rin(), "sel13_rand");
    shift_frame(mk_frame(11, 1), N, 1'b0, 16'h0, "sel11_shift");
    commit_idle("sel11_commit", 6);
    shift_frame(mk_frame(-1, 0), N, 1'b0, 16'h0, "dis_shift");
    cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, "dis_commit");
    cyc(1'b0, 1'b0, 1'b0, 16'hFFFF, "dis_ones");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, rin(), "dis_rand");

    // random frame lengths and commit timing
    for (int r = 0; r < 8; r++) begin
      shift_frame(mk_frame(-1, -1), $urandom_range(N - 2, N + 2), 1'b0, 16'h0, "rnd_shift");
      cyc(1'b0, 1'b0, 1'b0, rin(), "rnd_gap");
      commit_idle("rnd_commit", 2);
    end

    // make sure a known non-zero config is active, then reset mid-cycle
    shift_frame(mk_frame(-1, 1), N, 1'b0, 16'h0, "pre_rst_shift");
    commit_idle("pre_rst_commit", 1);
    rst_cyc(1'b0, 16'hFFFF, "async_reset");
    rst_cyc(1'b1, rin(), "async_release");

    // reset released mid-frame leaves an empty frame
    shift_frame(mk_frame(-1, -1), 50, 1'b0, 16'h0, "mid_shift");
    rst_cyc(1'b0, rin(), "mid_reset");
    rst_cyc(1'b1, rin(), "mid_release");
    shift_frame(mk_frame(-1, -1), 60, 1'b0, 16'h0, "mid_partial");
    commit_idle("mid_partial_commit", 2);
    shift_frame(mk_frame(-1, 1), N, 1'b0, 16'h0, "mid_full");
    commit_idle("mid_full_commit", 4);

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
